// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  function automatic int unsigned baud_cnt(input int unsigned clk, input int unsigned bps);
    return clk / bps;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial input plus received-byte outputs.
interface uart_rx_if;

  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       uart_rx_frame_err;
  logic       uart_rx_busy;

  modport master (
    input  uart_rxd,
    output uart_rx_data,
    output uart_rx_done,
    output uart_rx_frame_err,
    output uart_rx_busy
  );

  modport slave (
    output uart_rxd,
    input  uart_rx_data,
    input  uart_rx_done,
    input  uart_rx_frame_err,
    input  uart_rx_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with selectable reset value.
module sync_2ff #(
  parameter int unsigned     Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done / frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BPS     = 115_200,
  parameter int unsigned CLK_FRE = 50_000_000
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  uart_rx_if.master bus_io
);

  localparam int unsigned BaudCnt = baud_cnt(CLK_FRE, BPS);
  localparam int unsigned HalfCnt = BaudCnt / 2;
  localparam int unsigned CntW    = $clog2(BaudCnt);
  localparam logic [CntW-1:0] CntLast = CntW'(BaudCnt - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HalfCnt - 1);

  if (BaudCnt < 4) begin : gen_param_check
    $error("uart_rx: CLK_FRE/BPS must be at least 4");
  end

  logic rxd_sync;
  logic fall;

  uart_state_e     state_q,    state_d;
  logic [CntW-1:0] cnt_q,      cnt_d;
  logic [2:0]      idx_q,      idx_d;
  logic [7:0]      shreg_q,    shreg_d;
  logic [7:0]      data_q,     data_d;
  logic            done_q,     done_d;
  logic            ferr_q,     ferr_d;
  logic            busy_q,     busy_d;
  logic            rxd_prev_q;

  sync_2ff #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (bus_io.uart_rxd),
    .q_o   (rxd_sync)
  );

  assign fall = rxd_prev_q & ~rxd_sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = StStart;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is high again at its midpoint was a glitch.
          if (rxd_sync) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shreg_d[idx_q] = rxd_sync;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          if (rxd_sync) begin
            data_d = shreg_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      rxd_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      rxd_prev_q <= rxd_sync;
    end
  end

  assign bus_io.uart_rx_data      = data_q;
  assign bus_io.uart_rx_done      = done_q;
  assign bus_io.uart_rx_frame_err = ferr_q;
  assign bus_io.uart_rx_busy      = busy_q;

endmodule
